aes_dom_rand_feed: RTL and testbench

Fresh-randomness feeder and issue gate for the first-order DOM-indep GF(2^N) multipliers of the masked AES S-box. It takes wide entropy words from the PRNG over a req/ack handshake and buffers them bit-exactly. Each multiplier enable cycle, it dispenses a disjoint NumMul×NPower-bit slice as resharing masks `z_0`. It asserts the multipliers' `we_i` only when enough unused randomness is buffered, so no mask bit is ever reused.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_dom_rand_buf.sv | 70 +++++++
 rtl/aes_dom_rand_feed.sv | 96 +++++++++
 tb/tb_aes_dom_rand_feed.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared parameter helpers for the masked AES S-box datapath: width
// derivations for the DOM randomness feeder and the field-power legality
// check used by both the feeder and the DOM-indep GF(2^N) multipliers.
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

   // Fresh-randomness bits consumed per multiplier enable cycle.
   function automatic int unsigned cons_width(input int unsigned npower,
                                              input int unsigned num_mul);
      return npower * num_mul;
   endfunction

   // The randomness buffer holds two PRNG words so a new word can be
   // requested while a full word's worth of bits is still pending.
   function automatic int unsigned buf_width(input int unsigned entropy_width);
      return 2 * entropy_width;
   endfunction

   // DOM multipliers are only built for GF(2^2) and GF(2^4).
   function automatic bit npower_legal(input int unsigned npower);
      return (npower == 2) || (npower == 4);
   endfunction

endpackage

// File: rtl/aes_dom_rand_buf.sv
// ---------------------------------------------------------------------------
// aes_dom_rand_buf
// Bit-granular randomness shift buffer. Valid bits live in
// buf_q[fill_q-1:0], oldest at bit 0; everything above fill_q is zero.
// A consume drops the ConsW oldest bits, an append writes InW new bits just
// above the bits that remain after the consume.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clear_i        synchronous flush (wins over consume/append)
//   consume_i      remove the ConsW oldest bits (caller guarantees fill>=ConsW)
//   append_i       append data_i (caller guarantees room after consume)
//   data_i         InW-bit word to append
//   head_o         the ConsW oldest bits
//   fill_o         number of valid bits
// ---------------------------------------------------------------------------
module aes_dom_rand_buf #(
   parameter int unsigned BufW  = 64,
   parameter int unsigned ConsW = 12,
   parameter int unsigned InW   = 32,
   parameter int unsigned CntW  = $clog2(BufW + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            consume_i,
   input  logic            append_i,
   input  logic [InW-1:0]  data_i,
   output logic [ConsW-1:0] head_o,
   output logic [CntW-1:0] fill_o
);

   localparam logic [CntW-1:0] ConsCnt = CntW'(ConsW);
   localparam logic [CntW-1:0] InCnt   = CntW'(InW);

   logic [BufW-1:0] buf_q, buf_d, buf_shift;
   logic [CntW-1:0] fill_q, fill_d, fill_shift;

   always_comb begin
      // Consume is applied before append so the new word lands directly
      // above whatever survives this cycle's consume.
      buf_shift  = consume_i ? (buf_q >> ConsW) : buf_q;
      fill_shift = consume_i ? (fill_q - ConsCnt) : fill_q;
      buf_d      = buf_shift;
      fill_d     = fill_shift;
      if (append_i) begin
         // OR is sufficient because all bits above the fill level are zero.
         buf_d  = buf_shift | (BufW'(data_i) << fill_shift);
         fill_d = fill_shift + InCnt;
      end
      if (clear_i) begin
         buf_d  = '0;
         fill_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_q  <= '0;
         fill_q <= '0;
      end else begin
         buf_q  <= buf_d;
         fill_q <= fill_d;
      end
   end

   assign head_o = buf_q[ConsW-1:0];
   assign fill_o = fill_q;

endmodule

// File: rtl/aes_dom_rand_feed.sv
// ---------------------------------------------------------------------------
// aes_dom_rand_feed
// Fresh-randomness feeder and issue gate for the first-order DOM-indep
// multipliers of the masked AES S-box. PRNG words arrive over req/ack and
// are buffered bit-exactly; each enable cycle hands out a disjoint
// NumMul*NPower-bit slice as resharing masks, and the enable is only raised
// when that many unused bits are buffered, so no mask bit is reused.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous flush of all buffered randomness
//   entropy_req_o   request a PRNG word (room for a full word)
//   entropy_ack_i   PRNG word valid on entropy_i (honoured only with req)
//   entropy_i       PRNG word
//   in_valid_i      upstream operands available
//   in_ready_o      enough randomness buffered to issue
//   we_o            multiplier enable (combinational)
//   z_o             masks, multiplier k uses [k*NPower +: NPower]; zero when idle
//   out_valid_o     we_o delayed one cycle (multiplier output valid)
// ---------------------------------------------------------------------------
module aes_dom_rand_feed
   import aes_pkg::*;
#(
   parameter int unsigned NPower       = 4,
   parameter int unsigned NumMul       = 3,
   parameter int unsigned EntropyWidth = 32,
   localparam int unsigned ConsW       = cons_width(NPower, NumMul),
   localparam int unsigned BufW        = buf_width(EntropyWidth),
   localparam int unsigned CntW        = $clog2(BufW + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   output logic                    entropy_req_o,
   input  logic                    entropy_ack_i,
   input  logic [EntropyWidth-1:0] entropy_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   output logic                    we_o,
   output logic [ConsW-1:0]        z_o,
   output logic                    out_valid_o
);

   if (!npower_legal(NPower)) begin : gen_npower_illegal
      $error("aes_dom_rand_feed: NPower must be 2 or 4");
   end
   if (EntropyWidth < ConsW) begin : gen_entropy_too_narrow
      $error("aes_dom_rand_feed: EntropyWidth must be >= NumMul*NPower");
   end

   localparam logic [CntW-1:0] ConsCnt = CntW'(ConsW);
   localparam logic [CntW-1:0] RoomMax = CntW'(BufW - EntropyWidth);

   logic [CntW-1:0]  fill;
   logic [ConsW-1:0] head;
   logic             accept;
   logic             vld_p1;

   aes_dom_rand_buf #(
      .BufW  (BufW),
      .ConsW (ConsW),
      .InW   (EntropyWidth),
      .CntW  (CntW)
   ) u_buf (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i),
      .consume_i (we_o),
      .append_i  (accept),
      .data_i    (entropy_i),
      .head_o    (head),
      .fill_o    (fill)
   );

   // The room check deliberately ignores a same-cycle consume: it keeps the
   // request independent of in_valid_i and so free of upstream timing.
   assign entropy_req_o = (fill <= RoomMax) && !clear_i;
   assign accept        = entropy_ack_i && entropy_req_o;

   assign in_ready_o = (fill >= ConsCnt) && !clear_i;
   assign we_o       = in_valid_i && in_ready_o;
   // Zero-gate so no fresh bit is exposed on idle cycles.
   assign z_o        = we_o ? head : '0;

   // Stage p0 -> p1: matches the multipliers' one-register latency.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= we_o;
      end
   end

   assign out_valid_o = vld_p1;

endmodule

// File: tb/tb_aes_dom_rand_feed.sv
module tb_aes_dom_rand_feed;
   localparam int ConsW = 12;
   localparam int EW    = 32;
   localparam int BufW  = 64;

   logic          clk = 1'b0;
   logic          rst_ni, clear_i, entropy_ack_i, in_valid_i;
   logic [EW-1:0] entropy_i;
   logic          entropy_req_o, in_ready_o, we_o, out_valid_o;
   logic [ConsW-1:0] z_o;

   always #5 clk = ~clk;

   aes_dom_rand_feed dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .entropy_req_o (entropy_req_o),
      .entropy_ack_i (entropy_ack_i),
      .entropy_i     (entropy_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .we_o          (we_o),
      .z_o           (z_o),
      .out_valid_o   (out_valid_o)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // Scoreboard: bit queue of every accepted PRNG bit, oldest first.
   bit q[$];
   logic exp_req, exp_ready, exp_we, exp_ov;
   logic [ConsW-1:0] exp_z;
   int exp_fill;

   // Drive inputs (just after a rising edge) and compute expected values
   // at the falling edge from the scoreboard state.
   task automatic apply(input logic ack, input logic [EW-1:0] word,
                        input logic valid, input logic clr);
      entropy_ack_i = ack;
      entropy_i     = word;
      in_valid_i    = valid;
      clear_i       = clr;
      @(negedge clk);
      exp_fill  = q.size();
      exp_req   = (exp_fill <= BufW - EW) && !clr;
      exp_ready = (exp_fill >= ConsW) && !clr;
      exp_we    = valid && exp_ready;
      exp_z     = '0;
      if (exp_we) for (int i = 0; i < ConsW; i++) exp_z[i] = q[i];
   endtask

   // Update the scoreboard for this cycle and move past the next edge.
   task automatic advance();
      if (clear_i) q.delete();
      else begin
         if (exp_we) repeat (ConsW) void'(q.pop_front());
         if (entropy_ack_i && exp_req)
            for (int i = 0; i < EW; i++) q.push_back(entropy_i[i]);
      end
      exp_ov = exp_we;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; clear_i = 0; entropy_ack_i = 0; in_valid_i = 0; entropy_i = '0;
      q.delete(); exp_ov = 0;
      repeat (2) @(posedge clk);
      #1;
      apply(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (entropy_req_o !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b want 1", entropy_req_o); end
      n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", in_ready_o); end
      n_cmp++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we_o); end
      n_cmp++; if (z_o !== '0) begin n_fail++; $display("FAIL reset_z: got %h want 0", z_o); end
      n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", out_valid_o); end
      n_cmp++; if (dut.u_buf.fill_q !== 7'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", dut.u_buf.fill_q); end
      rst_ni = 1'b1;
      advance();
   endtask

   task automatic test_basic();
      apply(1'b0, '0, 1'b0, 1'b1); advance();
      apply(1'b1, 32'hA5A51234, 1'b0, 1'b0);
      n_cmp++; if (entropy_req_o !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %b want 1", entropy_req_o); end
      n_cmp++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL basic_we_empty: got %b want 0", we_o); end
      advance();
      apply(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (dut.u_buf.fill_q !== 7'd32) begin n_fail++; $display("FAIL basic_fill32: got %0d want 32", dut.u_buf.fill_q); end
      n_cmp++; if (we_o !== 1'b1 || z_o !== 12'h234) begin n_fail++; $display("FAIL basic_z0: got we=%b z=%h want we=1 z=234", we_o, z_o); end
      advance();
      apply(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (dut.u_buf.fill_q !== 7'd20) begin n_fail++; $display("FAIL basic_fill20: got %0d want 20", dut.u_buf.fill_q); end
      n_cmp++; if (we_o !== 1'b1 || z_o !== 12'hA51) begin n_fail++; $display("FAIL basic_z1: got we=%b z=%h want we=1 z=a51", we_o, z_o); end
      n_cmp++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_ov: got %b want 1", out_valid_o); end
      advance();
      apply(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (dut.u_buf.fill_q !== 7'd8) begin n_fail++; $display("FAIL basic_fill8: got %0d want 8", dut.u_buf.fill_q); end
      n_cmp++; if (we_o !== 1'b0 || z_o !== '0 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL basic_starved: got we=%b z=%h rdy=%b want 0/0/0", we_o, z_o, in_ready_o); end
      advance();
      apply(1'b0, '0, 1'b0, 1'b0);
      n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_ov_drop: got %b want 0", out_valid_o); end
      advance();
   endtask

   task automatic test_simul();
      logic [EW-1:0] w1, w2, w3;
      logic [51:0] exp52;
      logic [39:0] exp40;
      w1 = 32'h89AB_CDEF; w2 = 32'h1357_9BDF; w3 = 32'hFFFF_FFFF;
      exp52 = {w2, w1[31:12]};
      exp40 = {w2, w1[31:24]};
      apply(1'b0, '0, 1'b0, 1'b1); advance();
      apply(1'b1, w1, 1'b0, 1'b0); advance();
      apply(1'b1, w2, 1'b1, 1'b0);
      n_cmp++; if (entropy_req_o !== 1'b1 || we_o !== 1'b1 || z_o !== w1[11:0]) begin n_fail++; $display("FAIL simul_both: got req=%b we=%b z=%h want 1/1/%h", entropy_req_o, we_o, z_o, w1[11:0]); end
      advance();
      apply(1'b1, w3, 1'b1, 1'b0);
      n_cmp++; if (dut.u_buf.fill_q !== 7'd52) begin n_fail++; $display("FAIL simul_fill52: got %0d want 52", dut.u_buf.fill_q); end
      n_cmp++; if (dut.u_buf.buf_q[51:0] !== exp52) begin n_fail++; $display("FAIL simul_buf52: got %h want %h", dut.u_buf.buf_q[51:0], exp52); end
      n_cmp++; if (entropy_req_o !== 1'b0) begin n_fail++; $display("FAIL simul_full_req: got %b want 0", entropy_req_o); end
      n_cmp++; if (z_o !== w1[23:12]) begin n_fail++; $display("FAIL simul_z1: got %h want %h", z_o, w1[23:12]); end
      advance();
      apply(1'b0, '0, 1'b0, 1'b0);
      n_cmp++; if (dut.u_buf.fill_q !== 7'd40) begin n_fail++; $display("FAIL simul_fill40: got %0d want 40", dut.u_buf.fill_q); end
      n_cmp++; if (dut.u_buf.buf_q !== {24'h0, exp40}) begin n_fail++; $display("FAIL simul_buf40: got %h want %h", dut.u_buf.buf_q, {24'h0, exp40}); end
      advance();
   endtask

   task automatic test_ack_ignored();
      logic [BufW-1:0] snap;
      apply(1'b0, '0, 1'b1, 1'b0); advance();
      apply(1'b0, '0, 1'b1, 1'b0); advance();
      apply(1'b1, 32'h0F1E_2D3C, 1'b0, 1'b0); advance();
      apply(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      snap = dut.u_buf.buf_q;
      n_cmp++; if (dut.u_buf.fill_q !== 7'd48 || entropy_req_o !== 1'b0) begin n_fail++; $display("FAIL ign_pre: got fill=%0d req=%b want 48/0", dut.u_buf.fill_q, entropy_req_o); end
      advance();
      apply(1'b0, '0, 1'b0, 1'b0);
      n_cmp++; if (dut.u_buf.fill_q !== 7'd48) begin n_fail++; $display("FAIL ign_fill: got %0d want 48", dut.u_buf.fill_q); end
      n_cmp++; if (dut.u_buf.buf_q !== snap) begin n_fail++; $display("FAIL ign_buf: got %h want %h", dut.u_buf.buf_q, snap); end
      advance();
   endtask

   task automatic test_clear();
      apply(1'b1, 32'h1234_5678, 1'b1, 1'b1);
      n_cmp++; if (we_o !== 1'b0 || z_o !== '0 || in_ready_o !== 1'b0 || entropy_req_o !== 1'b0) begin n_fail++; $display("FAIL clr_same: got we=%b z=%h rdy=%b req=%b want 0/0/0/0", we_o, z_o, in_ready_o, entropy_req_o); end
      advance();
      apply(1'b0, '0, 1'b0, 1'b0);
      n_cmp++; if (dut.u_buf.fill_q !== 7'd0 || dut.u_buf.buf_q !== '0) begin n_fail++; $display("FAIL clr_next: got fill=%0d buf=%h want 0/0", dut.u_buf.fill_q, dut.u_buf.buf_q); end
      n_cmp++; if (entropy_req_o !== 1'b1) begin n_fail++; $display("FAIL clr_req: got %b want 1", entropy_req_o); end
      advance();
   endtask

   task automatic test_async_reset();
      apply(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0); advance();
      apply(1'b0, '0, 1'b1, 1'b0); advance();
      entropy_ack_i = 1'b0; in_valid_i = 1'b1; clear_i = 1'b0;
      #1;
      n_cmp++; if (out_valid_o !== 1'b1 || dut.u_buf.fill_q !== 7'd20 || we_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got ov=%b fill=%0d we=%b want 1/20/1", out_valid_o, dut.u_buf.fill_q, we_o); end
      #1 rst_ni = 1'b0;
      #1;
      n_cmp++; if (out_valid_o !== 1'b0 || dut.u_buf.fill_q !== 7'd0) begin n_fail++; $display("FAIL arst_state: got ov=%b fill=%0d want 0/0", out_valid_o, dut.u_buf.fill_q); end
      n_cmp++; if (entropy_req_o !== 1'b1 || in_ready_o !== 1'b0 || we_o !== 1'b0 || z_o !== '0) begin n_fail++; $display("FAIL arst_outs: got req=%b rdy=%b we=%b z=%h want 1/0/0/0", entropy_req_o, in_ready_o, we_o, z_o); end
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      q.delete(); exp_ov = 1'b0;
      apply(1'b0, '0, 1'b0, 1'b0);
      n_cmp++; if (dut.u_buf.fill_q !== 7'd0) begin n_fail++; $display("FAIL arst_release: got %0d want 0", dut.u_buf.fill_q); end
      advance();
   endtask

   task automatic test_stress();
      logic ack, valid, clr;
      logic [EW-1:0] word;
      for (int c = 0; c < 800; c++) begin
         ack   = 1'($urandom_range(0, 1));
         valid = ($urandom_range(0, 3) != 0);
         clr   = ($urandom_range(0, 79) == 0);
         word  = $urandom;
         apply(ack, word, valid, clr);
         n_cmp++;
         if ({entropy_req_o, in_ready_o, we_o, z_o, out_valid_o} !== {exp_req, exp_ready, exp_we, exp_z, exp_ov}) begin
            n_fail++;
            $display("FAIL stress_c%0d: got req=%b rdy=%b we=%b z=%h ov=%b want %b/%b/%b/%h/%b", c,
                     entropy_req_o, in_ready_o, we_o, z_o, out_valid_o, exp_req, exp_ready, exp_we, exp_z, exp_ov);
         end
         n_cmp++;
         if (int'(dut.u_buf.fill_q) != exp_fill) begin
            n_fail++;
            $display("FAIL stress_fill_c%0d: got %0d want %0d", c, dut.u_buf.fill_q, exp_fill);
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_simul();
      test_ack_ignored();
      test_clear();
      test_async_reset();
      test_stress();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
